// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the three-requester memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    REQ_DATA = 2'd0,
    REQ_INST = 2'd1,
    REQ_DMA  = 2'd2
  } req_e;

  localparam logic [7:0] MMIO_PAGE = 8'h7f;

  typedef logic [15:0] word_t;
  typedef logic [1:0]  be_t;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Fixed-priority selector (data > inst > DMA) with per-requester starvation promotion.
module mem_arbiter_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_req,
  output logic [2:0] o_gnt
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       w_starved;
  logic [2:0]       w_pool;
  logic [2:0]       w_sel;

  // Starved requesters form the candidate pool; ties inside it fall back to default order.
  always_comb begin
    w_starved = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_starved[k] = i_req[k] && (r_cnt[k] >= LIMIT);
    end
    w_pool = (|w_starved) ? w_starved : i_req;
    w_sel  = '0;
    if (w_pool[REQ_DATA])      w_sel[REQ_DATA] = 1'b1;
    else if (w_pool[REQ_INST]) w_sel[REQ_INST] = 1'b1;
    else if (w_pool[REQ_DMA])  w_sel[REQ_DMA]  = 1'b1;
  end

  assign o_gnt = i_rst_n ? w_sel : '0;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < 3; k++) r_cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (!i_req[k] || o_gnt[k]) r_cnt[k] <= '0;
        else if (r_cnt[k] < LIMIT)  r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for CPU data, CPU fetch and DMA requesters.
// Define MEM_ARBITER_MMIO_EN to steer page 8'h7f accesses to the io_* port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  be_t               d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              m_req,
  input  logic [ADDR_W-1:0] m_addr,
  input  be_t               m_we,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_gnt,
  output logic              m_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output be_t               mem_we,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_ARBITER_MMIO_EN
  output logic              io_en,
  output logic [ADDR_W-1:0] io_addr,
  output be_t               io_we,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [2:0]        w_req;
  logic [2:0]        w_gnt;
  logic [ADDR_W-1:0] w_addr;
  be_t               w_we;
  logic [DATA_W-1:0] w_wdata;
  logic              w_any;
  logic              w_io;
  logic              w_rd;
  logic [DATA_W-1:0] w_rsrc;
  logic [2:0]        r_rvalid;

  assign w_req[REQ_DATA] = d_req;
  assign w_req[REQ_INST] = i_req;
  assign w_req[REQ_DMA]  = m_req;

  mem_arbiter_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk    (clk),
    .i_rst_n(rst),
    .i_req  (w_req),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    w_addr  = '0;
    w_we    = '0;
    w_wdata = '0;
    if (w_gnt[REQ_DATA]) begin
      w_addr  = d_addr;
      w_we    = d_we;
      w_wdata = d_wdata;
    end else if (w_gnt[REQ_INST]) begin
      w_addr  = i_addr;
    end else if (w_gnt[REQ_DMA]) begin
      w_addr  = m_addr;
      w_we    = m_we;
      w_wdata = m_wdata;
    end
  end

  assign w_any = |w_gnt;
  assign w_rd  = w_any && (w_we == 2'b00);

`ifdef MEM_ARBITER_MMIO_EN
  logic r_rd_io;

  assign w_io     = w_any && (w_addr[ADDR_W-1 -: 8] == MMIO_PAGE);
  assign io_en    = w_io;
  assign io_addr  = w_addr;
  assign io_we    = w_io ? w_we : '0;
  assign io_wdata = w_wdata;

  // Remembers which slave answers the read returning next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_io <= 1'b0;
    else      r_rd_io <= w_io;
  end

  assign w_rsrc = r_rd_io ? io_rdata : mem_rdata;
`else
  assign w_io   = 1'b0;
  assign w_rsrc = mem_rdata;
`endif

  assign mem_en    = w_any && !w_io;
  assign mem_we    = mem_en ? w_we : '0;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;

  assign d_gnt = w_gnt[REQ_DATA];
  assign i_gnt = w_gnt[REQ_INST];
  assign m_gnt = w_gnt[REQ_DMA];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rvalid <= '0;
    else      r_rvalid <= w_rd ? w_gnt : '0;
  end

  assign d_rvalid = r_rvalid[REQ_DATA];
  assign i_rvalid = r_rvalid[REQ_INST];
  assign m_rvalid = r_rvalid[REQ_DMA];

  assign d_rdata = r_rvalid[REQ_DATA] ? w_rsrc : '0;
  assign i_rdata = r_rvalid[REQ_INST] ? w_rsrc : '0;
  assign m_rdata = r_rvalid[REQ_DMA]  ? w_rsrc : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed memory model; byte (a) resets to a[15:8]+a[7:0].
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        d_req, i_req, m_req;
  logic [15:0] d_addr, i_addr, m_addr;
  logic [1:0]  d_we, m_we;
  logic [15:0] d_wdata, m_wdata;
  logic        d_gnt, i_gnt, m_gnt;
  logic        d_rvalid, i_rvalid, m_rvalid;
  logic [15:0] d_rdata, i_rdata, m_rdata;
  logic        mem_en;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_we;
`ifdef MEM_ARBITER_MMIO_EN
  logic        io_en;
  logic [15:0] io_addr, io_wdata, io_rdata;
  logic [1:0]  io_we;
`endif

  int n_checks;
  int n_fail;

  logic [7:0] mem [65536];

  mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .STARVE_LIMIT(4)
  ) u_dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
`ifdef MEM_ARBITER_MMIO_EN
    .io_en(io_en), .io_addr(io_addr), .io_we(io_we), .io_wdata(io_wdata),
    .io_rdata(io_rdata),
`endif
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: we[0] -> even byte = data[15:8], we[1] -> odd byte = data[7:0].
  always @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < 65536; a++) mem[a] <= a[15:8] + a[7:0];
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we[0]) mem[{mem_addr[15:1], 1'b0}] <= mem_wdata[15:8];
      if (mem_we[1]) mem[{mem_addr[15:1], 1'b1}] <= mem_wdata[7:0];
      if (mem_we == 2'b00)
        mem_rdata <= {mem[{mem_addr[15:1], 1'b0}], mem[{mem_addr[15:1], 1'b1}]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    d_req = 1'b1; d_addr = 16'h0010; d_we = 2'b00; d_wdata = '0;
    i_req = 1'b1; i_addr = 16'h0020;
    m_req = 1'b1; m_addr = 16'hc000; m_we = 2'b00; m_wdata = '0;
`ifdef MEM_ARBITER_MMIO_EN
    io_rdata = 16'hBEEF;
`endif

    // Reset with all requests pending
    tick();
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_m_gnt", m_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid", {d_rvalid, i_rvalid, m_rvalid}, 0);
    chk("rst_rdata", d_rdata | i_rdata | m_rdata, 0);
    chk("rst_cnt_m", u_dut.u_prio.r_cnt[2], 0);

    // Three simultaneous reads: data, then fetch, then DMA
    rst = 1'b1;
    #1;
    chk("t1_d_gnt", {d_gnt, i_gnt, m_gnt}, 3'b100);
    chk("t1_d_addr", mem_addr, 16'h0010);
    chk("t1_d_en", mem_en, 1);
    tick();
    d_req = 1'b0;
    #1;
    chk("t1_d_rvalid", d_rvalid, 1);
    chk("t1_d_rdata", d_rdata, 16'h1011);
    chk("t1_i_gnt", {d_gnt, i_gnt, m_gnt}, 3'b010);
    chk("t1_i_addr", mem_addr, 16'h0020);
    chk("t1_i_we", mem_we, 2'b00);
    tick();
    i_req = 1'b0;
    #1;
    chk("t1_i_rvalid", i_rvalid, 1);
    chk("t1_i_rdata", i_rdata, 16'h2021);
    chk("t1_d_pulse", d_rvalid, 0);
    chk("t1_m_gnt", {d_gnt, i_gnt, m_gnt}, 3'b001);
    chk("t1_m_addr", mem_addr, 16'hc000);
    tick();
    m_req = 1'b0;
    #1;
    chk("t1_m_rvalid", m_rvalid, 1);
    chk("t1_m_rdata", m_rdata, 16'hC0C1);
    chk("t1_idle_en", mem_en, 0);
    chk("t1_idle_we", mem_we, 0);

    // Starvation: data hogs the port, DMA promoted after 4 denials
    d_req = 1'b1; d_addr = 16'h0100; d_we = 2'b11; d_wdata = 16'h5555;
    m_req = 1'b1; m_addr = 16'hc000; m_we = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("t2_d_hold", d_gnt, 1);
      chk("t2_m_denied", m_gnt, 0);
      tick();
    end
    #1;
    chk("t2_m_promoted", {d_gnt, i_gnt, m_gnt}, 3'b001);
    chk("t2_m_addr", mem_addr, 16'hc000);
    tick();
    m_req = 1'b0;
    #1;
    chk("t2_cnt_cleared", u_dut.u_prio.r_cnt[2], 0);
    chk("t2_m_rvalid", m_rvalid, 1);
    chk("t2_m_rdata", m_rdata, 16'hC0C1);
    chk("t2_d_back", d_gnt, 1);
    tick();
    d_req = 1'b0;

    // DMA byte write to the even byte, then read back
    m_req = 1'b1; m_addr = 16'hc002; m_we = 2'b01; m_wdata = 16'hABCD;
    #1;
    chk("t3_w_gnt", m_gnt, 1);
    chk("t3_w_we", mem_we, 2'b01);
    chk("t3_w_data", mem_wdata, 16'hABCD);
    chk("t3_w_addr", mem_addr, 16'hc002);
    tick();
    m_we = 2'b00;
    #1;
    chk("t3_w_no_rvalid", m_rvalid, 0);
    chk("t3_r_gnt", m_gnt, 1);
    tick();
    m_req = 1'b0;
    #1;
    chk("t3_r_rvalid", m_rvalid, 1);
    chk("t3_r_rdata", m_rdata, 16'hABC3);

    // Access to page 0x7f
    d_req = 1'b1; d_addr = 16'h7f00; d_we = 2'b11; d_wdata = 16'h1234;
    #1;
`ifdef MEM_ARBITER_MMIO_EN
    chk("t4_io_en", io_en, 1);
    chk("t4_io_wdata", io_wdata, 16'h1234);
    chk("t4_io_we", io_we, 2'b11);
    chk("t4_mem_en", mem_en, 0);
    tick();
    d_we = 2'b00; d_addr = 16'h7f02;
    #1;
    chk("t4_w_no_rvalid", d_rvalid, 0);
    chk("t4_io_rd_en", io_en, 1);
    chk("t4_io_rd_mem", mem_en, 0);
    tick();
    d_req = 1'b0;
    #1;
    chk("t4_io_rvalid", d_rvalid, 1);
    chk("t4_io_rdata", d_rdata, 16'hBEEF);
`else
    chk("t4_mem_en", mem_en, 1);
    chk("t4_mem_addr", mem_addr, 16'h7f00);
    chk("t4_mem_wdata", mem_wdata, 16'h1234);
    tick();
    d_req = 1'b0;
    #1;
    chk("t4_w_no_rvalid", d_rvalid, 0);
`endif

    // Alternating data write / fetch read, no idle cycles
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        d_req = 1'b1; d_addr = 16'h0200 + 16'(2 * k); d_we = 2'b11; d_wdata = 16'(k);
        i_req = 1'b0;
      end else begin
        d_req = 1'b0;
        i_req = 1'b1; i_addr = 16'h0030;
      end
      #1;
      chk("t5_mem_en", mem_en, 1);
      chk("t5_mem_we", mem_we, (k % 2 == 0) ? 2'b11 : 2'b00);
      if (k % 2 == 0 && k > 0) begin
        chk("t5_i_rvalid", i_rvalid, 1);
        chk("t5_i_rdata", i_rdata, 16'h3031);
      end
      tick();
    end
    d_req = 1'b0; i_req = 1'b0;
    #1;
    chk("t5_last_rvalid", i_rvalid, 1);
    chk("t5_last_rdata", i_rdata, 16'h3031);

    // Reset asserted half a cycle after a fetch grant
    i_req = 1'b1; i_addr = 16'h0040;
    #1;
    chk("t6_i_gnt", i_gnt, 1);
    @(negedge clk);
    rst = 1'b0;
    d_req = 1'b1; d_addr = 16'h0010; d_we = 2'b00;
    #1;
    chk("t6_rst_i_gnt", i_gnt, 0);
    chk("t6_rst_mem_en", mem_en, 0);
    tick();
    chk("t6_no_rvalid", i_rvalid, 0);
    chk("t6_rdata_zero", i_rdata, 0);
    chk("t6_gnt_zero", {d_gnt, i_gnt, m_gnt}, 0);
    chk("t6_mem_we", mem_we, 0);
    d_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_first_gnt", i_gnt, 1);
    chk("t6_first_addr", mem_addr, 16'h0040);
    tick();
    i_req = 1'b0;
    #1;
    chk("t6_rvalid", i_rvalid, 1);
    chk("t6_rdata", i_rdata, 16'h4041);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning byte address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied cycles before a requester is promoted.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  in  1  meaning the asynchronous, active-low reset.
REQ-006 SHALL have port ports d_req/d_addr/d_we[1:0]/d_wdata  in  1/16/2/16  meaning the CPU data requester.
REQ-007 SHALL have port d_gnt, d_rvalid, d_rdata  out  1/1/16  meaning the data grant and read return.
REQ-008 SHALL have port ports i_req/i_addr  in  1/16  meaning the CPU instruction fetch (read-only).
REQ-009 SHALL have port i_gnt, i_rvalid, i_rdata  out  1/1/16  meaning the fetch grant and read return.
REQ-010 SHALL have port ports m_req/m_addr/m_we[1:0]/m_wdata  in  1/16/2/16  meaning the DMA/image-loader requester.
REQ-011 SHALL have port m_gnt, m_rvalid, m_rdata  out  1/1/16  meaning the DMA grant and read return.
REQ-012 SHALL have port ports mem_en/mem_addr/mem_we[1:0]/mem_wdata  out  1/16/2/16  meaning the single-port memory command.
REQ-013 SHALL have port mem_rdata  in  16  meaning the memory read data, valid one cycle after mem_en.

Function
REQ-014 SHALL grant at most one requester per cycle; the grant is combinational from the req inputs and the registered arbitration state.
REQ-015 SHALL use default priority data > instruction > DMA.
REQ-016 SHALL count, per requester, the consecutive cycles it has req=1 and gnt=0; on reaching STARVE_LIMIT, that requester has top priority until granted.
REQ-017 SHALL resolve simultaneous starvation among several requesters by the default priority.
REQ-018 SHALL clear a requester's starvation counter on its grant or when its req=0.
REQ-019 SHALL, on grant in cycle N, drive mem_en=1 and forward addr/we/wdata unchanged in cycle N.
REQ-020 SHALL use byte-enable mapping we[0] = byte at (addr & ~1) = data[15:8], and we[1] = byte at (addr | 1) = data[7:0].
REQ-021 SHALL treat a grant with we=2'b00 as a read: the granted requester's rvalid=1 in cycle N+1 with rdata=mem_rdata; rvalid is a single-cycle pulse.
REQ-022 SHALL produce no rvalid for writes (we!=0).
REQ-023 SHALL require requesters to hold req and payload stable until gnt; a request withdrawn before gnt is dropped silently.
REQ-024 SHALL allow back-to-back grants every cycle (full throughput, no bubble between read and write).
REQ-025 SHALL hold mem_en=0 and mem_we=0 when no grant is given; mem_addr/mem_wdata are don't-care then.
REQ-026 SHALL, when i_req is granted, drive mem_we=00 regardless of other inputs.

Reset
REQ-027 SHALL, while rst=0, force all gnt, rvalid, mem_en=0, mem_we=00, all rdata=0, and starvation counters=0.
REQ-028 SHALL discard a read granted in the cycle rst asserts; no rvalid follows.
REQ-029 SHALL allow the first grant in the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, when MEM_ARBITER_MMIO_EN is defined, add ports io_en/io_addr/io_we[1:0]/io_wdata out and io_rdata in 16, and route granted accesses with addr[15:8]==8'h7f to io_* (mem_en=0); reads then return io_rdata at N+1.
REQ-031 SHALL, when MEM_ARBITER_MMIO_EN is undefined, omit the io_* ports and send all addresses to memory.

Structure
REQ-032 SHALL place the requester enum (REQ_DATA, REQ_INST, REQ_DMA), the MMIO_PAGE=8'h7f constant and the word/byte-enable typedefs in mem_arbiter_pkg.
REQ-033 SHALL implement the priority/starvation selection in one sub-module, mem_arbiter_prio, which outputs a one-hot grant.

Verification
REQ-034 SHALL verify: d_req, i_req, m_req all 1, reads at 0x0010/0x0020/0xc000 -> grants in order d, i, m over 3 cycles; each rvalid is one cycle after its grant with the correct word.
REQ-035 SHALL verify: d_req held 1 continuously, m_req=1 -> m_gnt at the latest on denied cycle STARVE_LIMIT+1 (cycle 5 for 4); counter is 0 afterwards.
REQ-036 SHALL verify: m write 0xABCD to 0xc002, we=01 -> only byte 0xc002=0xAB written; a read back returns 0xAB?? with the low byte unchanged.
REQ-037 SHALL verify: with MMIO_EN, d write 0x1234 to 0x7f00, we=11 -> io_en=1, io_wdata=0x1234, mem_en=0; without MMIO_EN, mem_en=1 for the same access.
REQ-038 SHALL verify: i read granted, rst=0 the next half-cycle -> no i_rvalid; all outputs 0 until release.
REQ-039 SHALL verify: alternating d write / i read every cycle -> mem_en=1 on every cycle with no bubble.
